// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver:
// frame state encoding, data width and the two line levels.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    // Idle line (mark) is high, the start bit (space) is low.
    localparam logic LINE_MARK  = 1'b1;
    localparam logic LINE_SPACE = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uartState_t;

endpackage

// File: rtl/uart_fifo_tx_if.sv
// Byte handshake between the host-side producer and the UART transmitter.
interface uart_fifo_tx_if;
    import uart_pkg::*;

    logic                      tx_validH;
    logic [UART_DATA_BITS-1:0] tx_dataH;
    logic                      tx_readyH;

    modport master (
        output tx_validH,
        output tx_dataH,
        input  tx_readyH
    );

    modport slave (
        input  tx_validH,
        input  tx_dataH,
        output tx_readyH
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO holding bytes waiting to be serialized.
// The read data is the head entry, valid whenever the FIFO is not empty.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_l,
    input  logic                   pushH,
    input  logic [WIDTH-1:0]       pushDataH,
    input  logic                   popH,
    output logic [WIDTH-1:0]       popDataH,
    output logic [$clog2(DEPTH):0] countH,
    output logic                   fullH,
    output logic                   emptyH
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    assign fullH    = (countH == CW'(DEPTH));
    assign emptyH   = (countH == '0);
    assign doPush   = pushH && !fullH;
    assign doPop    = popH && !emptyH;
    assign popDataH = mem[rdPtr];

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge sys_clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushDataH;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; a push and pop
    // on the same edge leave the count unchanged.
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            countH <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PW'(1);
            end
            case ({doPush, doPop})
                2'b10:   countH <= countH + CW'(1);
                2'b01:   countH <= countH - CW'(1);
                default: countH <= countH;
            endcase
        end
    end

endmodule

// File: rtl/uart_fifo_tx.sv
// Buffered UART transmitter: bytes enter a FIFO over a valid/ready
// handshake and leave as start, 8 data bits LSB first, optional even
// parity and stop, each bit lasting BIT_CLKS clocks. A new frame starts
// on the edge right after the previous stop bit when data is waiting.
module uart_fifo_tx
    import uart_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int BIT_CLKS  = 16,
    parameter int PARITY_EN = 0
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_l,
    uart_fifo_tx_if.slave          txIf,
    output logic                   uart_txH,
    output logic                   tx_busyH,
    output logic [$clog2(DEPTH):0] fifo_countH
);
    localparam int                CNT_W     = $clog2(BIT_CLKS);
    localparam logic [CNT_W-1:0]  LAST_CELL = CNT_W'(BIT_CLKS - 1);
    localparam logic [2:0]        LAST_BIT  = 3'(UART_DATA_BITS - 1);

    uartState_t                state;
    logic [CNT_W-1:0]          cellCnt;
    logic [2:0]                bitIdx;
    logic [UART_DATA_BITS-1:0] shiftReg;
    logic                      parityAcc;
    logic                      cellEnd;
    logic                      popReq;
    logic                      pushReq;
    logic                      fifoFull;
    logic                      fifoEmpty;
    logic [UART_DATA_BITS-1:0] popData;

    // Ready is derived from the registered count only, so a pop frees a
    // slot one cycle later and a push is never accepted into a full FIFO.
    assign txIf.tx_readyH = !fifoFull;
    assign pushReq        = txIf.tx_validH && txIf.tx_readyH;
    assign cellEnd        = (cellCnt == LAST_CELL);
    assign popReq         = !fifoEmpty &&
                            ((state == IDLE) || ((state == STOP) && cellEnd));

    uart_tx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) txFifo (
        .sys_clk   (sys_clk),
        .sys_rst_l (sys_rst_l),
        .pushH     (pushReq),
        .pushDataH (txIf.tx_dataH),
        .popH      (popReq),
        .popDataH  (popData),
        .countH    (fifo_countH),
        .fullH     (fifoFull),
        .emptyH    (fifoEmpty)
    );

    // Frame sequencer: every output is registered so the line never glitches,
    // and reset forces the line to mark immediately, dropping any partial frame.
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            state     <= IDLE;
            cellCnt   <= '0;
            bitIdx    <= '0;
            shiftReg  <= '0;
            parityAcc <= 1'b0;
            uart_txH  <= LINE_MARK;
            tx_busyH  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    uart_txH <= LINE_MARK;
                    if (popReq) begin
                        state     <= START;
                        shiftReg  <= popData;
                        parityAcc <= 1'b0;
                        cellCnt   <= '0;
                        bitIdx    <= '0;
                        uart_txH  <= LINE_SPACE;
                        tx_busyH  <= 1'b1;
                    end
                end

                START: begin
                    if (cellEnd) begin
                        cellCnt  <= '0;
                        state    <= DATA;
                        uart_txH <= shiftReg[0];
                    end else begin
                        cellCnt <= cellCnt + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (cellEnd) begin
                        cellCnt   <= '0;
                        shiftReg  <= shiftReg >> 1;
                        parityAcc <= parityAcc ^ shiftReg[0];
                        if (bitIdx == LAST_BIT) begin
                            bitIdx <= '0;
                            if (PARITY_EN != 0) begin
                                state    <= PARITY;
                                uart_txH <= parityAcc ^ shiftReg[0];
                            end else begin
                                state    <= STOP;
                                uart_txH <= LINE_MARK;
                            end
                        end else begin
                            bitIdx   <= bitIdx + 3'd1;
                            uart_txH <= shiftReg[1];
                        end
                    end else begin
                        cellCnt <= cellCnt + CNT_W'(1);
                    end
                end

                PARITY: begin
                    if (cellEnd) begin
                        cellCnt  <= '0;
                        state    <= STOP;
                        uart_txH <= LINE_MARK;
                    end else begin
                        cellCnt <= cellCnt + CNT_W'(1);
                    end
                end

                STOP: begin
                    if (cellEnd) begin
                        cellCnt <= '0;
                        if (popReq) begin
                            state     <= START;
                            shiftReg  <= popData;
                            parityAcc <= 1'b0;
                            bitIdx    <= '0;
                            uart_txH  <= LINE_SPACE;
                        end else begin
                            state    <= IDLE;
                            uart_txH <= LINE_MARK;
                            tx_busyH <= 1'b0;
                        end
                    end else begin
                        cellCnt <= cellCnt + CNT_W'(1);
                    end
                end

                default: begin
                    state    <= IDLE;
                    cellCnt  <= '0;
                    bitIdx   <= '0;
                    uart_txH <= LINE_MARK;
                    tx_busyH <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_fifo_tx.md
# uart_fifo_tx

Buffered UART transmitter for the RS232 link. It accepts bytes over a valid/ready handshake into a small synchronous FIFO and serializes them onto the line. Each frame is one start bit, 8 data bits LSB first, an optional even-parity bit and one stop bit, with every bit held for BIT_CLKS system clocks. It is the transmit-side counterpart of the 16x-oversampled UART receiver and sits between the host-side byte producer and the serial output pin.

## Interface
- DEPTH, 4, FIFO depth in bytes; must be a power of two, ≥2.
- BIT_CLKS, 16, sys_clk cycles per serial bit; ≥2.
- PARITY_EN, 0, 1 inserts an even-parity bit after bit 7.
- sys_clk  input  1  clock; all state changes on the rising edge.
- sys_rst_l  input  1  reset, asynchronous, active-low.
- tx_validH  input  1  producer presents a byte.
- tx_dataH  input  8  byte to send; sampled when tx_validH && tx_readyH.
- tx_readyH  output  1  FIFO can accept; equals (fifo_countH < DEPTH).
- uart_txH  output  1  serial line, registered, idles high.
- tx_busyH  output  1  high whenever the FSM is not in IDLE.
- fifo_countH  output  clog2(DEPTH)+1  bytes currently queued, registered.

## Operation
- Reset values: uart_txH=1, tx_readyH=1, tx_busyH=0, fifo_countH=0, FSM=IDLE, bit-cell counter=0, bit index=0.
- Push: a byte is accepted on any edge with tx_validH && tx_readyH. When full, tx_readyH=0 and tx_validH is ignored; no overwrite.
- Pop: the FSM pops in two cases:
  - in IDLE, when fifo_countH>0;
  - on the final cycle of STOP, when fifo_countH>0.
- Simultaneous push and pop: fifo_countH is unchanged. Read and write pointers wrap modulo DEPTH.
- FSM states are IDLE, START, DATA, PARITY, STOP.
  - IDLE: uart_txH=1. On a pop, load the shift register and go to START.
  - START: uart_txH=0 for BIT_CLKS cycles, then go to DATA.
  - DATA: uart_txH=shift[0], each bit held BIT_CLKS cycles, shift right after each bit. After bit 7, go to PARITY if PARITY_EN, else go to STOP.
  - PARITY: uart_txH = XOR of the 8 data bits, held BIT_CLKS cycles, then go to STOP.
  - STOP: uart_txH=1 for BIT_CLKS cycles. On the last cycle, go to START with a pop if the FIFO is non-empty, else go to IDLE.
- Bit-cell counter counts 0..BIT_CLKS-1 and wraps at each bit boundary. Bit index counts 0..7.
- The line output is driven from a register. It never glitches and never emits X.
- Reset asserted mid-frame: all state clears immediately, FIFO contents are discarded, and uart_txH returns high asynchronously. No partial frame resumes after reset release.

## Timing
- Latency: push at edge N into an empty, idle block → the byte is popped and uart_txH falls at edge N+1.
- Frame length is exactly (10+PARITY_EN)×BIT_CLKS cycles, measured from the start-bit falling edge to the end of the stop bit.
- Back-to-back frames have zero idle cycles: the next start bit begins on the edge right after the last stop-bit cycle.
- tx_readyH is combinational from the registered count, so a pop does not raise ready in the same cycle.
- tx_busyH rises with the start bit. It falls on the edge after the last stop-bit cycle, and only if the FIFO is empty.

## Structure
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - UART_DATA_BITS=8;
  - the idle/mark and space line levels.
  
  The receiver shares this package.
- One sub-module, uart_tx_fifo: a synchronous DEPTH×8 FIFO with push/pop, count, and full/empty flags.
- The top level contains the FSM, bit-cell counter, bit index, shift register and parity accumulator.

## Test plan
- Single byte 0xA5, BIT_CLKS=16, PARITY_EN=0 → the line reads 0, 1,0,1,0,0,1,0,1, 1, each bit 16 cycles. Start falls 1 cycle after the push edge. Busy is high for 160 cycles.
- Four bytes 0x00, 0xFF, 0x55, 0xAA pushed on consecutive cycles → four frames in 640 cycles with no gap between stop and start. fifo_countH peaks at 3.
- tx_validH held high continuously, DEPTH=4 → 5 bytes accepted (one popped immediately). tx_readyH=0 until the first STOP completes. Refused data is never sent.
- PARITY_EN=1, byte 0x07 → parity bit=1 and frame length 176 cycles. Byte 0x03 → parity bit=0.
- Reset pulsed 50 cycles into a frame with 2 bytes queued → uart_txH=1 and fifo_countH=0 immediately. The line stays idle after release until a new push.
- Push on the same edge as a STOP-end pop with count=4 → ready=0, so the push is refused and count goes to 3. Then a push with count=3 and a simultaneous pop → count stays at 3.
